// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator keypad entry path.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTRADA_A = 2'b00,
        ENTRADA_B = 2'b01,
        RESULTADO = 2'b10
    } estado_t;

    typedef enum logic [1:0] {
        SOMA = 2'b00,
        SUB  = 2'b01,
        MULT = 2'b10
    } operador_t;

    localparam logic [3:0] TECLA_SOMA  = 4'hA;
    localparam logic [3:0] TECLA_SUB   = 4'hB;
    localparam logic [3:0] TECLA_MULT  = 4'hC;
    localparam logic [3:0] TECLA_IGUAL = 4'hD;
    localparam logic [3:0] TECLA_LIMPA = 4'hE;
    localparam logic [3:0] TECLA_APAGA = 4'hF;

    function automatic logic eh_digito(input logic [3:0] tecla);
        return tecla <= 4'd9;
    endfunction

    function automatic logic eh_operador(input logic [3:0] tecla);
        return (tecla == TECLA_SOMA) || (tecla == TECLA_SUB) || (tecla == TECLA_MULT);
    endfunction

    function automatic logic [1:0] para_operador(input logic [3:0] tecla);
        logic [1:0] op;
        case (tecla)
            TECLA_SUB:  op = SUB;
            TECLA_MULT: op = MULT;
            default:    op = SOMA;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/registro_operando.sv
// One BCD operand register: shifts digits in at the LSD, drops the LSD on backspace.
module registro_operando #(
    parameter int DIGITOS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             desloca_entra,
    input  logic                             desloca_sai,
    input  logic                             limpa,
    input  logic                             carrega,
    input  logic [3:0]                       digito,
    output logic [4*DIGITOS-1:0]             operando,
    output logic [$clog2(DIGITOS+1)-1:0]     cont,
    output logic                             cheio
);

    localparam int W  = 4 * DIGITOS;
    localparam int CW = $clog2(DIGITOS + 1);

    logic [W-1:0] digito_ext;

    assign digito_ext = W'(digito);
    assign cheio      = (cont == CW'(DIGITOS));

    // Clear beats load beats shift; a full register ignores further shift-ins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operando <= '0;
            cont     <= '0;
        end else if (limpa) begin
            operando <= '0;
            cont     <= '0;
        end else if (carrega) begin
            operando <= digito_ext;
            cont     <= CW'(1);
        end else if (desloca_entra && !cheio) begin
            operando <= (operando << 4) | digito_ext;
            cont     <= cont + CW'(1);
        end else if (desloca_sai && (cont != '0)) begin
            operando <= operando >> 4;
            cont     <= cont - CW'(1);
        end
    end

endmodule

// File: rtl/sequenciador_entrada_calc.sv
// Keypad entry sequencer: edge-detects key strobes, builds operands A/B, latches the operator.
module sequenciador_entrada_calc
    import calc_pkg::*;
#(
    parameter int DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ready,
    input  logic [3:0]             valor,
    output logic [1:0]             estado,
    output logic [4*DIGITOS-1:0]   operando_a,
    output logic [4*DIGITOS-1:0]   operando_b,
    output logic [1:0]             operador,
    output logic                   calcular,
    output logic                   tecla_aceita,
    output logic                   tecla_rejeitada,
    output logic                   estouro
);

    localparam int CW = $clog2(DIGITOS + 1);

    localparam logic [1:0] EST_A        = ENTRADA_A;
    localparam logic [1:0] EST_B        = ENTRADA_B;
    localparam logic [1:0] EST_RES      = RESULTADO;
    localparam logic [1:0] EST_INVALIDO = 2'b11;

    logic          ready_q, armado, evento;
    logic [CW-1:0] cont_a, cont_b;
    logic          cheio_a, cheio_b;
    logic          entra_a, sai_a, limpa_a, carrega_a;
    logic          entra_b, sai_b, limpa_b;
    logic [1:0]    estado_prox, operador_prox;
    logic          calcular_prox, aceita_prox, rejeita_prox, estouro_prox;

    // armado stays low until ready is seen low, so a key already held at reset release is ignored.
    assign evento = ready && !ready_q && armado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            armado  <= 1'b0;
        end else begin
            ready_q <= ready;
            if (!ready) armado <= 1'b1;
        end
    end

    always_comb begin
        estado_prox   = estado;
        operador_prox = operador;
        estouro_prox  = estouro;
        calcular_prox = 1'b0;
        aceita_prox   = 1'b0;
        rejeita_prox  = 1'b0;
        entra_a       = 1'b0;
        sai_a         = 1'b0;
        limpa_a       = 1'b0;
        carrega_a     = 1'b0;
        entra_b       = 1'b0;
        sai_b         = 1'b0;
        limpa_b       = 1'b0;

        if (estado == EST_INVALIDO || (evento && valor == TECLA_LIMPA)) begin
            limpa_a       = 1'b1;
            limpa_b       = 1'b1;
            estado_prox   = EST_A;
            operador_prox = SOMA;
            estouro_prox  = 1'b0;
            aceita_prox   = evento && (valor == TECLA_LIMPA);
            rejeita_prox  = evento && (valor != TECLA_LIMPA);
        end else if (evento) begin
            case (estado)
                EST_A: begin
                    if (eh_digito(valor)) begin
                        if (cheio_a) begin
                            estouro_prox = 1'b1;
                            rejeita_prox = 1'b1;
                        end else begin
                            entra_a     = 1'b1;
                            aceita_prox = 1'b1;
                        end
                    end else if (valor == TECLA_APAGA) begin
                        sai_a        = (cont_a != '0);
                        aceita_prox  = (cont_a != '0);
                        rejeita_prox = (cont_a == '0);
                    end else if (eh_operador(valor) && cont_a != '0) begin
                        operador_prox = para_operador(valor);
                        estado_prox   = EST_B;
                        aceita_prox   = 1'b1;
                    end else begin
                        rejeita_prox = 1'b1;
                    end
                end
                EST_B: begin
                    if (eh_digito(valor)) begin
                        if (cheio_b) begin
                            estouro_prox = 1'b1;
                            rejeita_prox = 1'b1;
                        end else begin
                            entra_b     = 1'b1;
                            aceita_prox = 1'b1;
                        end
                    end else if (valor == TECLA_APAGA) begin
                        sai_b        = (cont_b != '0);
                        aceita_prox  = (cont_b != '0);
                        rejeita_prox = (cont_b == '0);
                    end else if (eh_operador(valor)) begin
                        operador_prox = para_operador(valor);
                        aceita_prox   = 1'b1;
                    end else if (valor == TECLA_IGUAL && cont_b != '0) begin
                        estado_prox   = EST_RES;
                        calcular_prox = 1'b1;
                        aceita_prox   = 1'b1;
                    end else begin
                        rejeita_prox = 1'b1;
                    end
                end
                EST_RES: begin
                    // A fresh digit starts a new calculation; the result itself is the ALU's business.
                    if (eh_digito(valor)) begin
                        carrega_a    = 1'b1;
                        limpa_b      = 1'b1;
                        estouro_prox = 1'b0;
                        estado_prox  = EST_A;
                        aceita_prox  = 1'b1;
                    end else begin
                        rejeita_prox = 1'b1;
                    end
                end
                default: rejeita_prox = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= EST_A;
            operador        <= SOMA;
            calcular        <= 1'b0;
            tecla_aceita    <= 1'b0;
            tecla_rejeitada <= 1'b0;
            estouro         <= 1'b0;
        end else begin
            estado          <= estado_prox;
            operador        <= operador_prox;
            calcular        <= calcular_prox;
            tecla_aceita    <= aceita_prox;
            tecla_rejeitada <= rejeita_prox;
            estouro         <= estouro_prox;
        end
    end

    registro_operando #(.DIGITOS(DIGITOS)) reg_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .desloca_entra (entra_a),
        .desloca_sai   (sai_a),
        .limpa         (limpa_a),
        .carrega       (carrega_a),
        .digito        (valor),
        .operando      (operando_a),
        .cont          (cont_a),
        .cheio         (cheio_a)
    );

    registro_operando #(.DIGITOS(DIGITOS)) reg_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .desloca_entra (entra_b),
        .desloca_sai   (sai_b),
        .limpa         (limpa_b),
        .carrega       (1'b0),
        .digito        (valor),
        .operando      (operando_b),
        .cont          (cont_b),
        .cheio         (cheio_b)
    );

endmodule

// File: tb/tb_sequenciador_entrada_calc.sv
// Bench for sequenciador_entrada_calc: digit-queue reference model plus directed key sequences.
module tb_sequenciador_entrada_calc;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready;
    logic [3:0]    valor;
    logic [1:0]    estado;
    logic [W-1:0]  operando_a, operando_b;
    logic [1:0]    operador;
    logic          calcular, tecla_aceita, tecla_rejeitada, estouro;

    int total = 0;
    int bad   = 0;
    int cnt_calc = 0, cnt_aceita = 0, cnt_rejeita = 0;

    // Reference model: operands as digit lists, most significant digit first.
    int         qa[$];
    int         qb[$];
    logic [1:0] m_estado;
    logic [1:0] m_op;
    logic       m_estouro, m_calc, m_ac, m_rej, m_prev_ready;

    sequenciador_entrada_calc #(.DIGITOS(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ready           (ready),
        .valor           (valor),
        .estado          (estado),
        .operando_a      (operando_a),
        .operando_b      (operando_b),
        .operador        (operador),
        .calcular        (calcular),
        .tecla_aceita    (tecla_aceita),
        .tecla_rejeitada (tecla_rejeitada),
        .estouro         (estouro)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] valor_fila(input int q[$]);
        logic [W-1:0] v;
        v = '0;
        foreach (q[i]) v = (v << 4) | W'(q[i]);
        return v;
    endfunction

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic modelo_limpa();
        qa.delete();
        qb.delete();
        m_estado  = 2'd0;
        m_op      = 2'd0;
        m_estouro = 1'b0;
    endtask

    task automatic modelo_tecla(input int k);
        if (k == 14) begin
            modelo_limpa();
            m_ac = 1'b1;
        end else if (m_estado == 2'd0 || m_estado == 2'd1) begin
            if (k <= 9) begin
                if ((m_estado == 2'd0 ? qa.size() : qb.size()) >= D) begin
                    m_estouro = 1'b1;
                    m_rej     = 1'b1;
                end else begin
                    if (m_estado == 2'd0) qa.push_back(k); else qb.push_back(k);
                    m_ac = 1'b1;
                end
            end else if (k == 15) begin
                if (m_estado == 2'd0 && qa.size() > 0) begin
                    void'(qa.pop_back());
                    m_ac = 1'b1;
                end else if (m_estado == 2'd1 && qb.size() > 0) begin
                    void'(qb.pop_back());
                    m_ac = 1'b1;
                end else m_rej = 1'b1;
            end else if (k >= 10 && k <= 12) begin
                if (m_estado == 2'd1 || qa.size() > 0) begin
                    m_op     = 2'(k - 10);
                    m_estado = 2'd1;
                    m_ac     = 1'b1;
                end else m_rej = 1'b1;
            end else begin
                if (m_estado == 2'd1 && qb.size() > 0) begin
                    m_estado = 2'd2;
                    m_calc   = 1'b1;
                    m_ac     = 1'b1;
                end else m_rej = 1'b1;
            end
        end else begin
            if (k <= 9) begin
                qa.delete();
                qb.delete();
                qa.push_back(k);
                m_estouro = 1'b0;
                m_estado  = 2'd0;
                m_ac      = 1'b1;
            end else m_rej = 1'b1;
        end
    endtask

    // Model step; a key already held when reset releases must fall before it counts.
    initial begin
        modelo_limpa();
        {m_calc, m_ac, m_rej} = 3'b000;
        m_prev_ready = 1'b1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelo_limpa();
                {m_calc, m_ac, m_rej} = 3'b000;
                m_prev_ready = 1'b1;
            end else begin
                {m_calc, m_ac, m_rej} = 3'b000;
                if (ready && !m_prev_ready) modelo_tecla(int'(valor));
                m_prev_ready = ready;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("estado", 32'(estado), 32'(m_estado));
                checkOutput("operando_a", 32'(operando_a), 32'(valor_fila(qa)));
                checkOutput("operando_b", 32'(operando_b), 32'(valor_fila(qb)));
                checkOutput("operador", 32'(operador), 32'(m_op));
                checkOutput("calcular", 32'(calcular), 32'(m_calc));
                checkOutput("tecla_aceita", 32'(tecla_aceita), 32'(m_ac));
                checkOutput("tecla_rejeitada", 32'(tecla_rejeitada), 32'(m_rej));
                checkOutput("estouro", 32'(estouro), 32'(m_estouro));
            end
            cnt_calc    += int'(calcular);
            cnt_aceita  += int'(tecla_aceita);
            cnt_rejeita += int'(tecla_rejeitada);
        end
    end

    task automatic applyStimulus(input logic [3:0] k, input int alto = 3, input int baixo = 2);
        @(posedge clk);
        #1;
        ready = 1'b1;
        valor = k;
        repeat (alto) @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (baixo) @(posedge clk);
        #1;
    endtask

    task automatic zeraContadores();
        cnt_calc    = 0;
        cnt_aceita  = 0;
        cnt_rejeita = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        valor = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_estado", 32'(estado), 32'h0);
        checkOutput("reset_a", 32'(operando_a), 32'h0);
        checkOutput("reset_pulsos", 32'({calcular, tecla_aceita, tecla_rejeitada, estouro}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        zeraContadores();
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'hA);
        checkOutput("seq_estado_b", 32'(estado), 32'h1);
        applyStimulus(4'h3);
        applyStimulus(4'hD);
        checkOutput("seq_a", 32'(operando_a), 32'h0012);
        checkOutput("seq_b", 32'(operando_b), 32'h0003);
        checkOutput("seq_op", 32'(operador), 32'h0);
        checkOutput("seq_estado_res", 32'(estado), 32'h2);
        checkOutput("seq_calc_count", 32'(cnt_calc), 32'd1);

        applyStimulus(4'hE);
        zeraContadores();
        applyStimulus(4'h7, 10, 2);
        checkOutput("held_a", 32'(operando_a), 32'h0007);
        checkOutput("held_aceita_count", 32'(cnt_aceita), 32'd1);

        applyStimulus(4'hE);
        zeraContadores();
        applyStimulus(4'h9);
        applyStimulus(4'h8);
        applyStimulus(4'h7);
        applyStimulus(4'h6);
        applyStimulus(4'h5);
        checkOutput("ovf_a", 32'(operando_a), 32'h9876);
        checkOutput("ovf_estouro", 32'(estouro), 32'h1);
        checkOutput("ovf_rej_count", 32'(cnt_rejeita), 32'd1);
        applyStimulus(4'hF);
        checkOutput("bksp_a", 32'(operando_a), 32'h0987);
        checkOutput("bksp_cont", 32'(dut.cont_a), 32'd3);
        checkOutput("bksp_estouro", 32'(estouro), 32'h1);
        applyStimulus(4'hE);
        checkOutput("clr_a", 32'(operando_a), 32'h0);
        checkOutput("clr_estouro", 32'(estouro), 32'h0);

        zeraContadores();
        applyStimulus(4'hA);
        applyStimulus(4'hD);
        applyStimulus(4'hF);
        checkOutput("empty_rej_count", 32'(cnt_rejeita), 32'd3);
        checkOutput("empty_ac_count", 32'(cnt_aceita), 32'd0);
        checkOutput("empty_estado", 32'(estado), 32'h0);
        applyStimulus(4'h5);
        applyStimulus(4'hB);
        applyStimulus(4'hC);
        applyStimulus(4'h2);
        applyStimulus(4'hD);
        checkOutput("relatch_op", 32'(operador), 32'h2);
        checkOutput("relatch_calc_count", 32'(cnt_calc), 32'd1);

        applyStimulus(4'hA);
        checkOutput("res_hold_a", 32'(operando_a), 32'h0005);
        checkOutput("res_hold_b", 32'(operando_b), 32'h0002);
        checkOutput("res_hold_estado", 32'(estado), 32'h2);
        applyStimulus(4'h4);
        checkOutput("res_new_a", 32'(operando_a), 32'h0004);
        checkOutput("res_new_b", 32'(operando_b), 32'h0);
        checkOutput("res_new_estado", 32'(estado), 32'h0);

        applyStimulus(4'h3);
        applyStimulus(4'hB);
        applyStimulus(4'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ready = 1'b1;
        valor = 4'h6;
        #1;
        checkOutput("async_estado", 32'(estado), 32'h0);
        checkOutput("async_a", 32'(operando_a), 32'h0);
        checkOutput("async_b", 32'(operando_b), 32'h0);
        checkOutput("async_op", 32'(operador), 32'h0);
        #3;
        rst_n = 1'b1;
        zeraContadores();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("held_release_ac", 32'(cnt_aceita), 32'd0);
        checkOutput("held_release_a", 32'(operando_a), 32'h0);
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(4'h6);
        checkOutput("after_toggle_a", 32'(operando_a), 32'h0006);
        checkOutput("after_toggle_ac", 32'(cnt_aceita), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
